// File: rtl/ssd_value_sequencer.sv
// ssd_value_sequencer: debug-word slots rotated onto dout/slot/valid for the 7-seg driver (clk, rstn, wr_*, clr, hold, step); SSD_SEQ_FOLLOW_WRITE_EN makes writes jump the display
module ssd_value_sequencer #(
  parameter int NUM_SLOTS = 4,
  parameter int DWELL_CYCLES = 100000000,
  localparam int AW = $clog2(NUM_SLOTS),
  localparam int CW = $clog2(DWELL_CYCLES)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [31:0]          wr_data,
  input  logic                 clr,
  input  logic                 hold,
  input  logic                 step,
  output logic [31:0]          dout,
  output logic [AW-1:0]        slot,
  output logic [NUM_SLOTS-1:0] valid
);
  typedef enum logic [1:0] {EMPTY, RUN, PAUSED} state_t;
  state_t state_q, state_d;
  logic [31:0] mem_q [NUM_SLOTS];
  logic [31:0] mem_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] valid_q, valid_d;
  logic [AW-1:0] slot_q, slot_d, nxt, idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] dout_q, dout_d;
  logic found, running, wrap, adv;
  always_comb begin
    mem_d = mem_q;
    valid_d = valid_q;
    slot_d = slot_q;
    cnt_d = cnt_q;
    state_d = state_q;
    nxt = slot_q;
    idx = slot_q;
    found = 1'b0;
    running = state_q != EMPTY && !hold;
    wrap = running && cnt_q == CW'(DWELL_CYCLES - 1);
    adv = state_q != EMPTY && (step || wrap);
    if (wr_en && !clr) begin
      mem_d[wr_addr] = wr_data;
      valid_d[wr_addr] = 1'b1;
    end
    for (int i = 1; i <= NUM_SLOTS; i++) begin
      idx = AW'(32'(slot_q) + i);
      if (!found && valid_d[idx]) begin
        nxt = idx;
        found = 1'b1;
      end
    end
    if (clr) begin
      valid_d = '0;
      slot_d = '0;
      cnt_d = '0;
      state_d = EMPTY;
    end else if (state_q == EMPTY) begin
      slot_d = wr_en ? wr_addr : slot_q;
      cnt_d = '0;
      state_d = wr_en ? RUN : EMPTY;
    end else begin
      state_d = hold ? PAUSED : RUN;
      cnt_d = running ? (wrap ? '0 : cnt_q + 1'b1) : cnt_q;
      slot_d = adv ? nxt : slot_q;
      cnt_d = step ? '0 : cnt_d;
`ifdef SSD_SEQ_FOLLOW_WRITE_EN
      slot_d = wr_en ? wr_addr : slot_d;
      cnt_d = wr_en ? '0 : cnt_d;
`endif
    end
    dout_d = state_d == EMPTY ? 32'h0 : mem_d[slot_d];
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_SLOTS; i++) mem_q[i] <= '0;
      valid_q <= '0;
      slot_q <= '0;
      cnt_q <= '0;
      state_q <= EMPTY;
      dout_q <= '0;
    end else begin
      mem_q <= mem_d;
      valid_q <= valid_d;
      slot_q <= slot_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
      dout_q <= dout_d;
    end
  end
  assign dout = dout_q;
  assign slot = slot_q;
  assign valid = valid_q;
endmodule

// File: tb/tb_ssd_value_sequencer.sv
// tb_ssd_value_sequencer: directed and random stimulus checked against a cycle model of the slot sequencer
module tb_ssd_value_sequencer;
  localparam int N = 4;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rstn, wr_en, clr, hold, step;
  logic [1:0] wr_addr;
  logic [31:0] wr_data, dout;
  logic [1:0] slot;
  logic [N-1:0] valid;
  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] m_mem [N];
  logic [N-1:0] m_val;
  int m_slot, m_age;
  logic h_lvl;
  ssd_value_sequencer #(.NUM_SLOTS(N), .DWELL_CYCLES(D)) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr(clr), .hold(hold), .step(step), .dout(dout), .slot(slot), .valid(valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic int nxt_valid(input int cur);
    for (int k = 1; k <= N; k++)
      if (m_val[(cur + k) % N]) return (cur + k) % N;
    return cur;
  endfunction
  task automatic cyc(input logic r, input logic w, input int a, input logic [31:0] d,
                     input logic c, input logic h, input logic s);
    bit empty, adv;
    @(negedge clk);
    chk("dout", dout, m_val != 0 ? m_mem[m_slot] : 32'h0);
    chk("slot", 32'(slot), 32'(m_slot));
    chk("valid", 32'(valid), 32'(m_val));
    rstn = r; wr_en = w; wr_addr = a[1:0]; wr_data = d; clr = c; hold = h; step = s;
    if (!r) begin
      for (int i = 0; i < N; i++) m_mem[i] = 32'h0;
      m_val = '0; m_slot = 0; m_age = 0;
    end else if (c) begin
      m_val = '0; m_slot = 0; m_age = 0;
    end else begin
      empty = m_val == 0;
      if (w) begin
        m_mem[a] = d;
        m_val[a] = 1'b1;
      end
      if (empty) begin
        if (w) begin
          m_slot = a;
          m_age = 0;
        end
      end else begin
        adv = s;
        if (!h) begin
          m_age++;
          if (m_age == D) begin
            m_age = 0;
            adv = 1;
          end
        end
        if (adv) begin
          m_slot = nxt_valid(m_slot);
          if (s) m_age = 0;
        end
`ifdef SSD_SEQ_FOLLOW_WRITE_EN
        if (w) begin
          m_slot = a;
          m_age = 0;
        end
`endif
      end
    end
  endtask
  task automatic idle(input int n, input logic h);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 32'h0, 0, h, 0);
  endtask
  initial begin
    rstn = 0; wr_en = 0; wr_addr = 0; wr_data = 0; clr = 0; hold = 0; step = 0;
    for (int i = 0; i < N; i++) m_mem[i] = 32'h0;
    m_val = '0; m_slot = 0; m_age = 0;
    @(posedge clk);
    cyc(0, 0, 0, 32'h0, 0, 0, 0);
    cyc(0, 1, 1, 32'h1234, 0, 1, 1);
    idle(20, 0);
    cyc(1, 1, 2, 32'hDEADBEEF, 0, 0, 0);
    idle(12, 0);
    cyc(1, 0, 0, 32'h0, 1, 0, 0);
    cyc(1, 1, 0, 32'h11111111, 0, 0, 0);
    cyc(1, 1, 3, 32'h33333333, 0, 0, 0);
    idle(18, 0);
    idle(5, 1);
    cyc(1, 0, 0, 32'h0, 0, 1, 1);
    idle(4, 1);
    idle(10, 0);
    cyc(1, 1, 1, 32'hAA, 1, 0, 0);
    idle(4, 0);
    cyc(1, 1, 0, 32'hC0DE, 0, 0, 0);
    idle(2, 0);
    cyc(1, 1, 1, 32'h5A5A5A5A, 0, 0, 0);
    idle(10, 0);
    cyc(1, 1, 2, 32'h22, 0, 0, 1);
    idle(6, 0);
    h_lvl = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) h_lvl = ~h_lvl;
      cyc($urandom_range(149) != 0, $urandom_range(3) == 0, int'($urandom_range(3)), $urandom,
          $urandom_range(39) == 0, h_lvl, $urandom_range(9) == 0);
    end
    idle(1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
